// File: rtl/div_hilo_capture.sv
// Sequencing and HI/LO writeback around an external combinational signed divider.
// Latches operands on start, waits SETTLE_CYCLES, then captures quotient->LO and remainder->HI.
module div_hilo_capture #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] rem_in,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  // state | meaning
  // IDLE  | no operation, start and direct writes accepted
  // WAIT  | operands held on op_a/op_b while the divider settles
  // DONE  | result (or divide-by-zero) reported for one cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             div_zero_nxt;
  logic             load_ops;
  logic             capture;
  logic             wr_allowed;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    div_zero_nxt = div_zero;
    load_ops     = 1'b0;
    capture      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_ops = 1'b1;
          if (divisor_in != '0) begin
            cnt_nxt      = CNT_LOAD;
            div_zero_nxt = 1'b0;
            state_nxt    = S_WAIT;
          end else begin
            div_zero_nxt = 1'b1;
            state_nxt    = S_DONE;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Direct HI/LO writes are locked out while a result is pending so capture never collides.
  assign wr_allowed = (state != S_WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
    end else if (load_ops) begin
      op_a <= dividend_in;
      op_b <= divisor_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (capture) begin
      hi <= rem_in;
      lo <= quo_in;
    end else if (wr_allowed) begin
      if (hi_wr) hi <= wr_data;
      if (lo_wr) lo <= wr_data;
    end
  end

  assign busy = (state == S_WAIT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_div_hilo_capture.sv
// Directed self-checking bench for div_hilo_capture with a behavioural signed divider
// driven from the DUT's op_a/op_b.
module tb_div_hilo_capture;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend_in, divisor_in;
  logic [7:0] op_a, op_b;
  logic [7:0] quo_in, rem_in;
  logic       hi_wr, lo_wr;
  logic [7:0] wr_data;
  logic [7:0] hi, lo;
  logic       busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Divider: truncating quotient, remainder takes the dividend's sign.
  always_comb begin
    quo_in = 8'h00;
    rem_in = 8'h00;
    if (op_b != 8'h00) begin
      quo_in = 8'($signed(op_a) / $signed(op_b));
      rem_in = 8'($signed(op_a) % $signed(op_b));
    end
  end

  div_hilo_capture #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .op_a        (op_a),
    .op_b        (op_b),
    .quo_in      (quo_in),
    .rem_in      (rem_in),
    .hi_wr       (hi_wr),
    .lo_wr       (lo_wr),
    .wr_data     (wr_data),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend_in = 8'h00; divisor_in = 8'h00;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    checks++; if (hi !== 8'h00) begin errors++; $display("FAIL reset_hi: got %h expected 00", hi); end
    checks++; if (lo !== 8'h00) begin errors++; $display("FAIL reset_lo: got %h expected 00", lo); end
    checks++; if (op_a !== 8'h00 || op_b !== 8'h00) begin errors++; $display("FAIL reset_ops: got %h/%h expected 00/00", op_a, op_b); end
    checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero}); end
  endtask

  task automatic test_basic_divide();
    dividend_in = 8'd7; divisor_in = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_busy1: got busy=%b done=%b expected 1/0", busy, done); end
    checks++; if (op_a !== 8'd7 || op_b !== 8'd2) begin errors++; $display("FAIL basic_ops: got %h/%h expected 07/02", op_a, op_b); end
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_busy2: got busy=%b done=%b expected 1/0", busy, done); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1 || div_zero !== 1'b0) begin errors++; $display("FAIL basic_done: got busy=%b done=%b dz=%b expected 0/1/0", busy, done, div_zero); end
    checks++; if (lo !== 8'h03 || hi !== 8'h01) begin errors++; $display("FAIL basic_result: got lo=%h hi=%h expected 03/01", lo, hi); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_negative_dividend();
    dividend_in = 8'hF9; divisor_in = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL neg_done: got %b expected 1", done); end
    checks++; if (lo !== 8'hFD || hi !== 8'hFF) begin errors++; $display("FAIL neg_result: got lo=%h hi=%h expected FD/FF", lo, hi); end
    tick();
  endtask

  task automatic test_div_zero();
    hi_wr = 1'b1; wr_data = 8'h11;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b1; wr_data = 8'h22;
    tick();
    lo_wr = 1'b0;
    checks++; if (hi !== 8'h11 || lo !== 8'h22) begin errors++; $display("FAIL dz_preload: got hi=%h lo=%h expected 11/22", hi, lo); end
    dividend_in = 8'd5; divisor_in = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || div_zero !== 1'b1) begin errors++; $display("FAIL dz_flags: got busy=%b done=%b dz=%b expected 0/1/1", busy, done, div_zero); end
    checks++; if (hi !== 8'h11 || lo !== 8'h22) begin errors++; $display("FAIL dz_hold: got hi=%h lo=%h expected 11/22", hi, lo); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b1) begin errors++; $display("FAIL dz_after: got busy=%b done=%b dz=%b expected 0/0/1", busy, done, div_zero); end
  endtask

  task automatic test_back_to_back();
    dividend_in = 8'd100; divisor_in = 8'd7; start = 1'b1;
    tick();
    dividend_in = 8'd9; divisor_in = 8'hFD;
    checks++; if (busy !== 1'b1 || div_zero !== 1'b0) begin errors++; $display("FAIL b2b_busy: got busy=%b dz=%b expected 1/0", busy, div_zero); end
    tick();
    checks++; if (op_a !== 8'd100 || op_b !== 8'd7) begin errors++; $display("FAIL b2b_ops_stable: got %h/%h expected 64/07", op_a, op_b); end
    tick();
    checks++; if (done !== 1'b1 || lo !== 8'h0E || hi !== 8'h02) begin errors++; $display("FAIL b2b_first: got done=%b lo=%h hi=%h expected 1/0E/02", done, lo, hi); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b1 || op_a !== 8'd9 || op_b !== 8'hFD) begin errors++; $display("FAIL b2b_restart: got done=%b busy=%b ops=%h/%h expected 0/1/09/FD", done, busy, op_a, op_b); end
    tick(); tick();
    checks++; if (done !== 1'b1 || lo !== 8'hFD || hi !== 8'h00) begin errors++; $display("FAIL b2b_second: got done=%b lo=%h hi=%h expected 1/FD/00", done, lo, hi); end
    start = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_reset_mid_op();
    dividend_in = 8'd7; divisor_in = 8'd2; start = 1'b1;
    tick();
    start = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL rmid_flags: got %b expected 000", {busy, done, div_zero}); end
    checks++; if (hi !== 8'h00 || lo !== 8'h00 || op_a !== 8'h00 || op_b !== 8'h00) begin errors++; $display("FAIL rmid_regs: got hi=%h lo=%h ops=%h/%h expected zeros", hi, lo, op_a, op_b); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_nodone: got busy=%b done=%b expected 0/0", busy, done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (done !== 1'b1 || lo !== 8'h03 || hi !== 8'h01) begin errors++; $display("FAIL rmid_redo: got done=%b lo=%h hi=%h expected 1/03/01", done, lo, hi); end
    tick();
  endtask

  task automatic test_write_lockout();
    dividend_in = 8'd12; divisor_in = 8'd5; start = 1'b1;
    tick();
    start = 1'b0; hi_wr = 1'b1; wr_data = 8'h55;
    tick();
    checks++; if (hi !== 8'h01) begin errors++; $display("FAIL wlock_wait: got hi=%h expected 01", hi); end
    tick();
    hi_wr = 1'b0;
    checks++; if (done !== 1'b1 || hi !== 8'h02 || lo !== 8'h02) begin errors++; $display("FAIL wlock_done: got done=%b hi=%h lo=%h expected 1/02/02", done, hi, lo); end
    tick();
    hi_wr = 1'b1; wr_data = 8'h55;
    tick();
    hi_wr = 1'b0;
    checks++; if (hi !== 8'h55 || lo !== 8'h02) begin errors++; $display("FAIL wlock_idle: got hi=%h lo=%h expected 55/02", hi, lo); end
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 8'hA5;
    dividend_in = 8'd9; divisor_in = 8'd4; start = 1'b1;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0; start = 1'b0;
    checks++; if (hi !== 8'hA5 || lo !== 8'hA5 || busy !== 1'b1) begin errors++; $display("FAIL wboth_start: got hi=%h lo=%h busy=%b expected A5/A5/1", hi, lo, busy); end
    tick(); tick();
    checks++; if (done !== 1'b1 || lo !== 8'h02 || hi !== 8'h01) begin errors++; $display("FAIL wboth_result: got done=%b lo=%h hi=%h expected 1/02/01", done, lo, hi); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_divide();
    test_negative_dividend();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_write_lockout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
